ps2_rx_fifo: RTL and testbench

PS/2 keyboard receiver feeding the scan-code display path: samples the keyboard's `ps2_clk`/`ps2_data` lines in the system clock domain, deframes 11-bit PS/2 frames into scan-code bytes, and buffers them in a small FIFO. Downstream logic (scan-code FSM, ASCII lookup, seven-segment drivers) pops bytes with an active-low strobe. It also maintains a keystroke counter and a sticky overflow flag for display.

---
 rtl/ps2_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: 3-flop sync, 11-bit deframer, 2^FIFO_AW byte FIFO popped by active-low nextdata_n; byte lands one edge after stop sample.
// Full FIFO without a same-cycle pop drops the byte and sets sticky overflow. Define PS2_PARITY_CHECK_EN to reject odd-parity failures.
module ps2_rx_fifo #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       ready,
    input  logic       nextdata_n,
    output logic       overflow,
    output logic [7:0] key_count,
    output logic       frame_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_CHECK = 1'b1;
`else
    localparam bit PARITY_CHECK = 1'b0;
`endif

    logic [2:0]         clk_sync_q;
    logic [2:0]         dat_sync_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic [FIFO_AW:0]   wptr_q, rptr_q;
    logic [7:0]         mem_q [DEPTH];
    logic               ovf_q;
    logic               ferr_q;
    logic               brk_q, brk_d;
    logic [7:0]         kcnt_q, kcnt_d;

    logic fall;
    logic bit_s;
    logic frame_done;
    logic frame_ok;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic drop;

    // Data flop of the same age as the last-high clock flop: the value held just before the fall.
    assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_s = dat_sync_q[2];

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_done = 1'b0;
        frame_ok   = 1'b0;
        if (fall) begin
            if (cnt_q == 4'd0) begin
                if (!bit_s) begin
                    cnt_d = 4'd1;
                end
            end else if (cnt_q <= 4'd8) begin
                shift_d = {bit_s, shift_q[7:1]};
                cnt_d   = cnt_q + 4'd1;
            end else if (cnt_q == 4'd9) begin
                par_d = bit_s;
                cnt_d = 4'd10;
            end else begin
                frame_done = 1'b1;
                cnt_d      = 4'd0;
                frame_ok   = bit_s & (~PARITY_CHECK | (^{shift_q, par_q}));
            end
        end
    end

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign do_pop  = ~nextdata_n & ~empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign do_push = frame_ok & (~full | do_pop);
    assign drop    = frame_ok & full & ~do_pop;

    always_comb begin
        brk_d  = brk_q;
        kcnt_d = kcnt_q;
        if (frame_ok) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q != 8'hE0 && brk_q) begin
                kcnt_d = kcnt_q + 8'd1;
                brk_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            kcnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[1:0], ps2_data};
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            brk_q      <= brk_d;
            kcnt_q     <= kcnt_d;
            ferr_q     <= frame_done & ~frame_ok;
            if (do_push) begin
                mem_q[wptr_q[FIFO_AW-1:0]] <= shift_q;
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign data      = mem_q[rptr_q[FIFO_AW-1:0]];
    assign ready     = ~empty;
    assign overflow  = ovf_q;
    assign key_count = kcnt_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged on the PS/2 lines, expected bytes queued, a monitor pops and compares.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       ready;
    logic       nextdata_n;
    logic       overflow;
    logic [7:0] key_count;
    logic       frame_err;

    logic       mon_pop_n;
    logic       tb_pop_n;
    bit         auto_pop;

    logic [7:0] exp_q[$];
    bit         exp_brk;
    int         exp_key;
    bit         exp_ovf;
    int         exp_err;
    int         err_seen;
    int         n_tests;
    int         n_fail;

    assign nextdata_n = mon_pop_n & tb_pop_n;

    ps2_rx_fifo #(.FIFO_AW(3)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .ready      (ready),
        .nextdata_n (nextdata_n),
        .overflow   (overflow),
        .key_count  (key_count),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what a correct receiver holds after one complete frame.
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input bit pop_now, output logic [7:0] popped);
        bit valid;
        popped = 8'h00;
`ifdef PS2_PARITY_CHECK_EN
        valid = !bad_stop && !bad_par;
`else
        valid = !bad_stop;
`endif
        if (!valid) begin
            exp_err++;
            return;
        end
        if (b == 8'hF0) begin
            exp_brk = 1'b1;
        end else if (b != 8'hE0 && exp_brk) begin
            exp_key = (exp_key + 1) % 256;
            exp_brk = 1'b0;
        end
        if (pop_now) begin
            popped = exp_q.pop_front();
            exp_q.push_back(b);
        end else if (!auto_pop && exp_q.size() >= DEPTH) begin
            exp_ovf = 1'b1;
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit pop_stop);
        logic [10:0] bits;
        logic [7:0]  popped;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        popped = 8'h00;
        if (nbits == 11) model_frame(b, bad_par, bad_stop, pop_stop, popped);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            @(negedge clk);
            ps2_clk = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                // Stop sample is processed on the third edge after the raw fall.
                if (pop_stop && i == 10 && k == 2) begin
                    check("pop_on_stop_head", data, popped);
                    tb_pop_n = 1'b0;
                end
                if (pop_stop && i == 10 && k == 3) tb_pop_n = 1'b1;
            end
            ps2_clk = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        exp_q.delete();
        exp_brk = 1'b0;
        exp_key = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic drain_check(input int n_exp);
        int got;
        got = 0;
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            @(negedge clk);
            tb_pop_n = 1'b1;
            if (!ready) break;
            if (exp_q.size() == 0) begin
                check("drain_unexpected", data, 32'hFFFF_FFFF);
            end else begin
                check("drain_data", data, exp_q.pop_front());
            end
            tb_pop_n = 1'b0;
            got++;
        end
        tb_pop_n = 1'b1;
        @(negedge clk);
        check("drain_count", got, n_exp);
        check("drain_ready_low", ready, 1'b0);
        check("drain_model_left", exp_q.size(), 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ready) break;
        end
        check("drain_done", (exp_q.size() == 0 && ready == 1'b0), 1);
    endtask

    initial begin
        mon_pop_n = 1'b1;
        forever begin
            @(negedge clk);
            if (auto_pop && ready && mon_pop_n) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected", data, 32'hFFFF_FFFF);
                end else begin
                    check("mon_data", data, exp_q.pop_front());
                end
                mon_pop_n = 1'b0;
            end else begin
                mon_pop_n = 1'b1;
            end
        end
    end

    initial begin
        err_seen = 0;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) err_seen++;
        end
    end

    initial begin
        #1500us;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int err0;
        logic [7:0] rb;
        n_tests  = 0;
        n_fail   = 0;
        exp_err  = 0;
        auto_pop = 1'b0;
        tb_pop_n = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clrn     = 1'b1;
        repeat (3) @(negedge clk);
        clrn = 1'b0;
        exp_q.delete();
        exp_brk = 1'b0;
        exp_key = 0;
        exp_ovf = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_key_count", key_count, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);

        // Single byte then one pop.
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        check("single_ready", ready, 1'b1);
        check("single_data", data, 8'h1C);
        drain_check(1);

        // Release sequence: order preserved and one keystroke counted.
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        drain_check(3);
        check("release_key_count", key_count, 8'd1);

        // Nine bytes into eight slots.
        for (int i = 0; i < 9; i++) begin
            rb = 8'($urandom_range(0, 8'hDF));
            send_frame(rb, 1'b0, 1'b0, 11, 1'b0);
        end
        check("ovf_set", overflow, exp_ovf);
        check("ovf_set_const", overflow, 1'b1);
        drain_check(8);
        check("ovf_sticky", overflow, 1'b1);
        do_reset();
        @(negedge clk);
        check("ovf_cleared", overflow, 1'b0);
        check("reset_data_cleared", data, 8'h00);
        check("reset_key_count", key_count, 8'h00);

        // Parity error and stop error.
        err0 = err_seen;
        send_frame(8'h24, 1'b1, 1'b0, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("badpar_err_pulses", err_seen - err0, 1);
        drain_check(0);
`else
        check("badpar_err_pulses", err_seen - err0, 0);
        check("badpar_data", data, 8'h24);
        drain_check(1);
`endif
        err0 = err_seen;
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
        check("badstop_err_pulses", err_seen - err0, 1);
        drain_check(0);

        // Full FIFO with a pop landing on the stop-bit cycle.
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(8'h30 + i), 1'b0, 1'b0, 11, 1'b0);
        end
        send_frame(8'h77, 1'b0, 1'b0, 11, 1'b1);
        check("simul_no_ovf", overflow, 1'b0);
        drain_check(8);

        // Reset in the middle of a frame.
        send_frame(8'hAA, 1'b0, 1'b0, 6, 1'b0);
        do_reset();
        send_frame(8'h45, 1'b0, 1'b0, 11, 1'b0);
        check("midreset_data", data, 8'h45);
        drain_check(1);

        // Randomized traffic with live consumer.
        auto_pop = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            rb = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom_range(0, 255));
            send_frame(rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 11, 1'b0);
        end
        wait_drain();
        check("rand_key_count", key_count, exp_key);
        check("rand_frame_err", err_seen, exp_err);
        check("rand_overflow", overflow, 1'b0);

        // 256 releases wrap the counter.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0);
            send_frame(8'($urandom_range(0, 8'hDF)), 1'b0, 1'b0, 11, 1'b0);
            if (i == 254) check("key_count_255", key_count, 8'd255);
        end
        wait_drain();
        check("key_count_model", key_count, exp_key);
        check("key_count_wrap", key_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
